// File: rtl/fir_decimator.sv
// Boxcar accumulate-and-dump decimator (N = 2^dec_log2) feeding a small
// first-word-fall-through output FIFO with overflow statistics.
module fir_decimator #(
  parameter int WID    = 16,
  parameter int DEPTH  = 4,
  parameter int MAXLOG = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           din_vld,
  input  logic [WID-1:0] din,
  input  logic [2:0]     dec_log2,
  input  logic           clr_stat,
  output logic [WID-1:0] dout,
  output logic           dout_vld,
  input  logic           dout_rdy,
  output logic [2:0]     level,
  output logic           ovf,
  output logic [7:0]     drop_cnt
);

  localparam int ACCW = WID + MAXLOG;
  localparam int CW   = MAXLOG + 1;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] sum;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_last;
  logic [2:0]      el;
  logic [2:0]      el_new;
  logic [2:0]      el_eff;
  logic            last;
  logic [WID-1:0]  result;

  logic            push_pending;
  logic [WID-1:0]  push_data;

  logic [WID-1:0]  mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            full;
  logic            pop;
  logic            do_write;
  logic            drop;

  // The first sample of a window uses the freshly clamped exponent, so an
  // N=1 window closes on that very sample.
  always_comb begin
    el_new   = (dec_log2 > 3'(MAXLOG)) ? 3'(MAXLOG) : dec_log2;
    el_eff   = (cnt == '0) ? el_new : el;
    cnt_last = (CW'(1) << el_eff) - CW'(1);
    last     = (cnt == cnt_last);
    sum      = acc + ACCW'(din);
    result   = WID'(sum >> el_eff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      cnt          <= '0;
      el           <= '0;
      push_pending <= 1'b0;
      push_data    <= '0;
    end else begin
      push_pending <= 1'b0;
      if (din_vld) begin
        if (cnt == '0)
          el <= el_new;
        if (last) begin
          acc          <= '0;
          cnt          <= '0;
          push_pending <= 1'b1;
          push_data    <= result;
        end else begin
          acc <= sum;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign dout_vld = (level != 3'd0);
  assign dout     = mem[rd_ptr];
  assign full     = (level == 3'(DEPTH));
  assign pop      = dout_vld & dout_rdy;
  assign do_write = push_pending & (~full | pop);
  assign drop     = push_pending & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_write) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({do_write, pop})
        2'b10:   level <= level + 3'd1;
        2'b01:   level <= level - 3'd1;
        default: level <= level;
      endcase
    end
  end

  // A clear in the same cycle as a drop wins; that drop is not recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_stat) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fir_decimator.sv
// Directed-vector bench for fir_decimator; inputs change and outputs are
// sampled on the falling clock edge.
module tb_fir_decimator;

  logic        clk;
  logic        rst_n;
  logic        din_vld;
  logic [15:0] din;
  logic [2:0]  dec_log2;
  logic        clr_stat;
  logic [15:0] dout;
  logic        dout_vld;
  logic        dout_rdy;
  logic [2:0]  level;
  logic        ovf;
  logic [7:0]  drop_cnt;

  int total_checks;
  int passed_checks;

  fir_decimator #(.WID(16), .DEPTH(4), .MAXLOG(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_vld  (din_vld),
    .din      (din),
    .dec_log2 (dec_log2),
    .clr_stat (clr_stat),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .level    (level),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual === expected)
      passed_checks++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  // Drive one input cycle, then wait for the falling edge after its rising edge.
  task automatic applyStimulus(input logic vld, input logic [15:0] data);
    din_vld = vld;
    din     = data;
    @(negedge clk);
    din_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 16'd0);
  endtask

  task automatic popExpect(input string tag, input logic [15:0] expected);
    checkOutput({tag, "_vld"}, 32'(dout_vld), 32'd1);
    checkOutput(tag, 32'(dout), 32'(expected));
    dout_rdy = 1'b1;
    idle(1);
    dout_rdy = 1'b0;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst_n    = 1'b0;
    din_vld  = 1'b0;
    din      = '0;
    dec_log2 = '0;
    clr_stat = 1'b0;
    dout_rdy = 1'b0;

    #1;
    checkOutput("rst_vld",   32'(dout_vld), 32'd0);
    checkOutput("rst_level", 32'(level),    32'd0);
    checkOutput("rst_dout",  32'(dout),     32'd0);
    checkOutput("rst_ovf",   32'(ovf),      32'd0);
    checkOutput("rst_drop",  32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a partially accumulated window.
    dec_log2 = 3'd2;
    applyStimulus(1'b1, 16'd1);
    applyStimulus(1'b1, 16'd2);
    applyStimulus(1'b1, 16'd3);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'd10);
    applyStimulus(1'b1, 16'd20);
    applyStimulus(1'b1, 16'd30);
    applyStimulus(1'b1, 16'd40);
    idle(2);
    checkOutput("midrst_level", 32'(level), 32'd1);
    popExpect("midrst_dout", 16'd25);
    checkOutput("midrst_empty", 32'(level), 32'd0);

    // Averaging over four samples with a ready consumer, latency of 2.
    dout_rdy = 1'b1;
    applyStimulus(1'b1, 16'd100);
    applyStimulus(1'b1, 16'd200);
    applyStimulus(1'b1, 16'd300);
    applyStimulus(1'b1, 16'd401);
    checkOutput("avg_lat1_vld", 32'(dout_vld), 32'd0);
    idle(1);
    checkOutput("avg_lat2_vld", 32'(dout_vld), 32'd1);
    checkOutput("avg_dout", 32'(dout), 32'd250);
    idle(1);
    checkOutput("avg_popped", 32'(level), 32'd0);
    dout_rdy = 1'b0;

    // Exponent 7 is clamped to 16 samples; full-scale input must not wrap.
    dec_log2 = 3'd7;
    for (int i = 0; i < 15; i++)
      applyStimulus(1'b1, 16'hFFFF);
    idle(2);
    checkOutput("max_partial_level", 32'(level), 32'd0);
    applyStimulus(1'b1, 16'hFFFF);
    dec_log2 = 3'd0;
    applyStimulus(1'b1, 16'd5);
    applyStimulus(1'b1, 16'd6);
    idle(2);
    checkOutput("max_level", 32'(level), 32'd3);
    popExpect("max_dout", 16'hFFFF);
    popExpect("n1_first", 16'd5);
    popExpect("n1_second", 16'd6);

    // Overflow: six pushes into a four-entry FIFO with no consumer.
    for (int i = 1; i <= 6; i++)
      applyStimulus(1'b1, 16'(i));
    idle(2);
    checkOutput("ovf_level", 32'(level), 32'd4);
    checkOutput("ovf_dout", 32'(dout), 32'd1);
    checkOutput("ovf_flag", 32'(ovf), 32'd1);
    checkOutput("ovf_drops", 32'(drop_cnt), 32'd2);
    for (int i = 1; i <= 4; i++)
      popExpect("ovf_drain", 16'(i));
    checkOutput("ovf_drained", 32'(level), 32'd0);

    // Full FIFO: a push landing on the same edge as a pop is not dropped.
    for (int i = 1; i <= 4; i++)
      applyStimulus(1'b1, 16'(i));
    idle(2);
    checkOutput("full_level", 32'(level), 32'd4);
    applyStimulus(1'b1, 16'd9);
    dout_rdy = 1'b1;
    idle(1);
    dout_rdy = 1'b0;
    checkOutput("simul_level", 32'(level), 32'd4);
    checkOutput("simul_drops", 32'(drop_cnt), 32'd2);
    popExpect("simul_drain", 16'd2);
    popExpect("simul_drain", 16'd3);
    popExpect("simul_drain", 16'd4);
    popExpect("simul_drain", 16'd9);
    checkOutput("simul_empty", 32'(level), 32'd0);

    // Stalled input holds the window.
    dec_log2 = 3'd1;
    applyStimulus(1'b1, 16'd7);
    applyStimulus(1'b0, 16'd99);
    applyStimulus(1'b1, 16'd9);
    idle(2);
    checkOutput("stall_level", 32'(level), 32'd1);
    popExpect("stall_dout", 16'd8);

    // Exponent change mid-window only affects the following window.
    applyStimulus(1'b1, 16'd10);
    dec_log2 = 3'd3;
    applyStimulus(1'b1, 16'd20);
    for (int i = 1; i <= 8; i++)
      applyStimulus(1'b1, 16'(10 * i));
    idle(2);
    checkOutput("cfg_level", 32'(level), 32'd2);
    popExpect("cfg_old_window", 16'd15);
    popExpect("cfg_new_window", 16'd45);

    // Statistics clear.
    clr_stat = 1'b1;
    idle(1);
    clr_stat = 1'b0;
    checkOutput("clr_ovf", 32'(ovf), 32'd0);
    checkOutput("clr_drops", 32'(drop_cnt), 32'd0);

    // A clear on the same edge as a drop wins.
    dec_log2 = 3'd0;
    for (int i = 1; i <= 4; i++)
      applyStimulus(1'b1, 16'(i));
    idle(2);
    applyStimulus(1'b1, 16'd5);
    clr_stat = 1'b1;
    idle(1);
    clr_stat = 1'b0;
    checkOutput("clrwin_ovf", 32'(ovf), 32'd0);
    checkOutput("clrwin_drops", 32'(drop_cnt), 32'd0);
    checkOutput("clrwin_level", 32'(level), 32'd4);
    popExpect("clrwin_head", 16'd1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
